// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
// Shift-add multiply and restoring divide share one 64-bit accumulator; signs fixed up at the end.
module mult_div_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic        i_hi_we,
    input  logic        i_lo_we,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div0,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, a_raw_q, hi_q, lo_q, hi_d, lo_d;
    logic        neg_a_q, neg_b_q, done_q, div0_q, div0_d;
    logic [4:0]  cnt_q;

    logic        in_signed, in_neg_a, in_neg_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] sum, diff;
    logic [63:0] prod;
    logic [31:0] quot, rem;

    assign in_signed = ~i_op[0];
    assign in_neg_a  = in_signed & i_rs[31];
    assign in_neg_b  = in_signed & i_rt[31];
    assign mag_a     = in_neg_a ? -i_rs : i_rs;
    assign mag_b     = in_neg_b ? -i_rt : i_rt;

    always_comb begin
        sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        diff   = acc_q[63:31] - {1'b0, b_q};
        acc_d  = acc_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        div0_d = 1'b0;
        if (!op_q[1])
            acc_d = {sum, acc_q[31:1]};
        else if (diff[32])
            acc_d = {acc_q[62:0], 1'b0};
        else
            acc_d = {diff[31:0], acc_q[30:0], 1'b1};

        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot = (neg_a_q ^ neg_b_q) ? -acc_q[31:0] : acc_q[31:0];
        rem  = neg_a_q ? -acc_q[63:32] : acc_q[63:32];
        if (!op_q[1]) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
        end else if (b_q == 32'd0) begin
            // Divide by zero: hand back the original dividend, quotient all ones
            hi_d   = a_raw_q;
            lo_d   = 32'hFFFF_FFFF;
            div0_d = 1'b1;
        end else begin
            hi_d = rem;
            lo_d = quot;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 2'd0;
            acc_q   <= 64'd0;
            b_q     <= 32'd0;
            a_raw_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_CALC;
                        op_q    <= i_op;
                        acc_q   <= {32'd0, mag_a};
                        b_q     <= mag_b;
                        a_raw_q <= i_rs;
                        neg_a_q <= in_neg_a;
                        neg_b_q <= in_neg_b;
                        cnt_q   <= 5'd0;
                    end else begin
                        if (i_hi_we) hi_q <= i_wdata;
                        if (i_lo_we) lo_q <= i_wdata;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    div0_q  <= div0_d;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (state_q != S_IDLE);
    assign o_done = done_q;
    assign o_div0 = div0_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
// Results are predicted with 64-bit signed/unsigned arithmetic in a behavioural model.
module tb_mult_div_unit;

    logic        i_clk, i_rst_n, i_start, i_hi_we, i_lo_we;
    logic [1:0]  i_op;
    logic [31:0] i_rs, i_rt, i_wdata;
    logic        o_busy, o_done, o_div0;
    logic [31:0] o_hi, o_lo;

    int total = 0;
    int bad   = 0;

    mult_div_unit dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_rs(i_rs), .i_rt(i_rt), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
        .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_div0(o_div0),
        .o_hi(o_hi), .o_lo(o_lo)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic d0);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        logic [63:0]     p;
        d0 = 1'b0;
        hi = 32'd0;
        lo = 32'd0;
        if (op == 2'd0) begin
            p = sa * sb;
            hi = p[63:32]; lo = p[31:0];
        end else if (op == 2'd1) begin
            p = ua * ub;
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a; lo = 32'hFFFF_FFFF; d0 = 1'b1;
        end else if (op == 2'd2) begin
            p = sa / sb; lo = p[31:0];
            p = sa % sb; hi = p[31:0];
        end else begin
            p = ua / ub; lo = p[31:0];
            p = ua % ub; hi = p[31:0];
        end
    endfunction

    // Runs one operation; optionally injects a stray start / MTHI at given cycles after acceptance
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_start, input int inj_we,
                         output int cyc, output logic [31:0] hi, output logic [31:0] lo,
                         output logic d0, output logic busy_ok, output logic pulse_ok);
        @(negedge i_clk);
        i_op = op; i_rs = a; i_rt = b; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        busy_ok = (o_busy === 1'b1);
        cyc = 0;
        i_rs = $urandom; i_rt = $urandom; i_op = 2'($urandom);
        for (int k = 1; k <= 60; k++) begin
            i_start = (k == inj_start);
            i_hi_we = (k == inj_we);
            i_wdata = 32'h1234;
            @(posedge i_clk); #1;
            i_start = 1'b0; i_hi_we = 1'b0;
            if (o_done === 1'b1) begin
                cyc = k;
                break;
            end
            if (o_busy !== 1'b1) busy_ok = 1'b0;
        end
        hi = o_hi; lo = o_lo; d0 = o_div0;
        if (o_busy !== 1'b0) busy_ok = 1'b0;
        @(posedge i_clk); #1;
        pulse_ok = (o_done === 1'b0) && (o_div0 === 1'b0);
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0; i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
        i_op = 2'd0; i_rs = 32'd0; i_rt = 32'd0; i_wdata = 32'd0;
        repeat (2) @(posedge i_clk);
        #1;
        total++;
        if ({o_busy, o_done, o_div0} !== 3'b000 || o_hi !== 32'd0 || o_lo !== 32'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b div0=%b hi=%h lo=%h want all zero",
                     o_busy, o_done, o_div0, o_hi, o_lo);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0]  ops [5];
        logic [31:0] as  [5];
        logic [31:0] bs  [5];
        logic [31:0] eh  [5];
        logic [31:0] el  [5];
        logic        ed  [5];
        logic [31:0] hi, lo;
        logic        d0, bok, pok;
        int          cyc;
        ops[0] = 2'd1; as[0] = 32'hFFFF_FFFF; bs[0] = 32'hFFFF_FFFF; eh[0] = 32'hFFFF_FFFE; el[0] = 32'h1;          ed[0] = 0;
        ops[1] = 2'd0; as[1] = -32'sd3;       bs[1] = 32'd5;         eh[1] = 32'hFFFF_FFFF; el[1] = 32'hFFFF_FFF1;  ed[1] = 0;
        ops[2] = 2'd2; as[2] = -32'sd7;       bs[2] = 32'd2;         eh[2] = 32'hFFFF_FFFF; el[2] = 32'hFFFF_FFFD;  ed[2] = 0;
        ops[3] = 2'd3; as[3] = 32'd100;       bs[3] = 32'd0;         eh[3] = 32'd100;       el[3] = 32'hFFFF_FFFF;  ed[3] = 1;
        ops[4] = 2'd2; as[4] = 32'h8000_0000; bs[4] = 32'hFFFF_FFFF; eh[4] = 32'd0;         el[4] = 32'h8000_0000;  ed[4] = 0;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], 0, 0, cyc, hi, lo, d0, bok, pok);
            total++;
            if (cyc !== 33 || hi !== eh[i] || lo !== el[i] || d0 !== ed[i] || !bok || !pok) begin
                bad++;
                $display("FAIL directed%0d: cyc=%0d hi=%h lo=%h div0=%b busy_ok=%b pulse_ok=%b want cyc=33 hi=%h lo=%h div0=%b",
                         i, cyc, hi, lo, d0, bok, pok, eh[i], el[i], ed[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo, eh, el;
        logic        d0, ed, bok, pok;
        int          cyc;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 17);
                2: a = $urandom_range(0, 1000);
                3: b = -$urandom_range(1, 9);
                default: ;
            endcase
            model(op, a, b, eh, el, ed);
            do_op(op, a, b, 0, 0, cyc, hi, lo, d0, bok, pok);
            total++;
            if (cyc !== 33 || hi !== eh || lo !== el || d0 !== ed || !bok || !pok) begin
                bad++;
                $display("FAIL random%0d op=%0d a=%h b=%h: cyc=%0d hi=%h lo=%h div0=%b want hi=%h lo=%h div0=%b",
                         i, op, a, b, cyc, hi, lo, d0, eh, el, ed);
            end
        end
    endtask

    task automatic test_ignore_busy;
        logic [31:0] hi, lo, eh, el;
        logic        d0, ed, bok, pok;
        int          cyc;
        model(2'd0, 32'h1234_5678, -32'sd99, eh, el, ed);
        do_op(2'd0, 32'h1234_5678, -32'sd99, 5, 10, cyc, hi, lo, d0, bok, pok);
        total++;
        if (cyc !== 33 || hi !== eh || lo !== el || d0 !== ed || !bok || !pok) begin
            bad++;
            $display("FAIL ignore_busy: cyc=%0d hi=%h lo=%h want cyc=33 hi=%h lo=%h", cyc, hi, lo, eh, el);
        end
        repeat (3) @(posedge i_clk);
        #1;
        total++;
        if (o_busy !== 1'b0 || o_hi !== eh) begin
            bad++;
            $display("FAIL no_queue: busy=%b hi=%h want busy=0 hi=%h", o_busy, o_hi, eh);
        end
    endtask

    task automatic test_mt;
        logic [31:0] prev;
        @(negedge i_clk);
        i_hi_we = 1'b1; i_wdata = 32'hA5A5_A5A5;
        @(posedge i_clk); #1;
        i_hi_we = 1'b0;
        total++;
        if (o_hi !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL mthi: hi=%h want a5a5a5a5", o_hi);
        end
        @(negedge i_clk);
        i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'h0BAD_F00D;
        @(posedge i_clk); #1;
        i_hi_we = 1'b0; i_lo_we = 1'b0;
        total++;
        if (o_hi !== 32'h0BAD_F00D || o_lo !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h want 0badf00d both", o_hi, o_lo);
        end
        prev = o_hi;
        @(negedge i_clk);
        i_op = 2'd1; i_rs = 32'd2; i_rt = 32'd3; i_start = 1'b1;
        i_hi_we = 1'b1; i_wdata = 32'hA5A5_A5A5;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_hi_we = 1'b0;
        total++;
        if (o_hi !== prev || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL start_wins: hi=%h busy=%b want hi=%h busy=1", o_hi, o_busy, prev);
        end
        for (int k = 0; k < 60 && o_done !== 1'b1; k++) begin
            @(posedge i_clk); #1;
        end
        total++;
        if (o_done !== 1'b1 || o_hi !== 32'd0 || o_lo !== 32'd6) begin
            bad++;
            $display("FAIL start_wins_result: done=%b hi=%h lo=%h want done=1 hi=0 lo=6", o_done, o_hi, o_lo);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] hi, lo, eh, el;
        logic        d0, ed, bok, pok, saw_done;
        int          cyc;
        @(negedge i_clk);
        i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'h5555_AAAA;
        @(negedge i_clk);
        i_hi_we = 1'b0; i_lo_we = 1'b0;
        i_op = 2'd3; i_rs = 32'd1000; i_rt = 32'd7; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (15) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_busy !== 1'b0 || o_hi !== 32'd0 || o_lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0 0 0", o_busy, o_hi, o_lo);
        end
        saw_done = 1'b0;
        repeat (25) begin
            @(posedge i_clk); #1;
            if (o_done !== 1'b0) saw_done = 1'b1;
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (25) begin
            @(posedge i_clk); #1;
            if (o_done !== 1'b0) saw_done = 1'b1;
        end
        total++;
        if (saw_done || o_hi !== 32'd0 || o_lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_abort: saw_done=%b hi=%h lo=%h want 0 0 0", saw_done, o_hi, o_lo);
        end
        model(2'd3, 32'd1000, 32'd7, eh, el, ed);
        do_op(2'd3, 32'd1000, 32'd7, 0, 0, cyc, hi, lo, d0, bok, pok);
        total++;
        if (cyc !== 33 || hi !== eh || lo !== el || d0 !== ed || !bok || !pok) begin
            bad++;
            $display("FAIL after_reset: cyc=%0d hi=%h lo=%h want cyc=33 hi=%h lo=%h", cyc, hi, lo, eh, el);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_busy;
        test_mt;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 SHALL have i_clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have i_start, input, 1 bit: operation request, sampled at the rising edge.
REQ-005 SHALL have i_op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have i_rs, input, 32 bits: operand A (multiplicand or dividend), taken from register-file read port 1.
REQ-007 SHALL have i_rt, input, 32 bits: operand B (multiplier or divisor), taken from register-file read port 2.
REQ-008 SHALL have i_hi_we and i_lo_we, inputs, 1 bit each: MTHI / MTLO write enables.
REQ-009 SHALL have i_wdata, input, 32 bits: MTHI / MTLO write data.
REQ-010 SHALL have o_busy, output, 1 bit: an operation is in progress.
REQ-011 SHALL have o_done, output, 1 bit: registered one-cycle completion pulse.
REQ-012 SHALL have o_div0, output, 1 bit: registered pulse, coincident with o_done, flagging a divide by zero.
REQ-013 SHALL have o_hi and o_lo, outputs, 32 bits each: HI/LO register contents, for MFHI/MFLO.

Function
REQ-014 SHALL implement an FSM with three states:
- IDLE: i_start=1 -> CALC, latching i_op, |i_rs|, |i_rt|, the sign flags, and iteration count=0.
- CALC: one iteration per cycle; after the 32nd iteration -> FIX.
- FIX: applies sign correction, writes HI/LO, pulses o_done, then -> IDLE.
REQ-015 o_busy SHALL equal (state != IDLE).
- With acceptance at edge E0, o_busy SHALL be high from E0 to E33.
- HI/LO SHALL update at E33; o_done SHALL be high for exactly the cycle E33 to E34.
REQ-016 Multiply SHALL be radix-2 shift-add on the unsigned magnitudes, producing a 64-bit product; HI = product[63:32], LO = product[31:0].
REQ-017 Divide SHALL be restoring, one quotient bit per iteration; LO = quotient, HI = remainder.
REQ-018 Signed operations (MULT, DIV) SHALL operate on magnitudes, then two's-complement-negate in FIX:
- product: negated when the operand signs differ;
- quotient: negated when the operand signs differ;
- remainder: takes the sign of the dividend.
REQ-019 Unsigned operations SHALL skip the magnitude conversion and the FIX-state negation.
REQ-020 DIV with -2^31 / -1 SHALL give LO=0x80000000, HI=0, with no flag raised.
REQ-021 Divide by zero (i_rt=0 with DIV or DIVU) SHALL:
- still take the full 33-cycle latency;
- write HI=i_rs (as latched) and LO=0xFFFFFFFF;
- pulse o_div0 together with o_done.
REQ-022 i_start while o_busy=1 SHALL be ignored, with no queuing.
REQ-023 i_hi_we / i_lo_we in IDLE SHALL write i_wdata to HI / LO at the next edge; both may be asserted together.
REQ-024 i_hi_we / i_lo_we while o_busy=1 SHALL be ignored.
REQ-025 If i_start and a write enable are asserted together in IDLE, the start SHALL win and the write SHALL be dropped.
REQ-026 HI/LO SHALL hold their values between operations; operands SHALL be latched at acceptance, so later changes on i_rs/i_rt have no effect.

Reset
REQ-027 i_rst_n=0 SHALL immediately force:
- state = IDLE;
- HI = LO = 0 and all internal datapath registers = 0;
- o_busy = o_done = o_div0 = 0.
REQ-028 Assertion of i_rst_n mid-operation SHALL abort the operation with no HI/LO update and no o_done pulse.
REQ-029 The first i_start sampled at a rising edge after reset release SHALL be accepted normally.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF: o_busy high for 34 edges (E0 to E33); at E33, HI=0xFFFFFFFE, LO=0x00000001; o_done is a single-cycle pulse.
REQ-031 MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIVU 100 / 0 -> HI=100, LO=0xFFFFFFFF, o_div0 and o_done high in the same cycle; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 Second i_start at E5 of a MULT, and i_hi_we=1 with i_wdata=0x1234 at E10: both are ignored; the result matches a run without them.
REQ-034 i_hi_we=1 with i_wdata=0xA5A5A5A5 in IDLE -> o_hi=0xA5A5A5A5 after one edge; the same write asserted together with i_start is dropped.
REQ-035 i_rst_n=0 at E15 of a DIVU: o_busy drops immediately, HI=LO=0, and no o_done pulse occurs; a new op after release completes correctly.
